vram_arbiter: RTL
=================

# vram_arbiter

Single-port access controller for the 640x480 RGB332 frame buffer. It shares one VRAM port between three requesters:
- the VGA scan-out reader (display)
- a host pixel-write interface
- a built-in full-frame clear engine

It sits between the VGA timing/colour path and the VRAM in TOP. It guarantees the display never stalls, and it sequences the clear operation around display and host traffic.

## Interface
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- ADDR_W, 19, VRAM word address width (linear address = y*H_ACTIVE + x)
- DATA_W, 8, pixel width, RGB332 {r[2:0], g[2:0], b[1:0]}

Ports:
- clk  in  1  system clock, the only clock
- rstn  in  1  reset, asynchronous and active-low; all state clears immediately on assertion
- disp_req  in  1  display read request, one pixel per cycle
- disp_addr  in  ADDR_W  display read address
- disp_rdata  out  DATA_W  read data, equal to vram_rdata
- disp_rvalid  out  1  high one cycle after an accepted disp_req
- host_valid  in  1  host write request
- host_ready  out  1  host write accepted this cycle when valid&&ready
- host_addr  in  ADDR_W  host write address
- host_wdata  in  DATA_W  host write pixel
- clr_start  in  1  start full-frame clear (single-cycle pulse)
- clr_color  in  DATA_W  fill value, sampled on accepted clr_start
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse when the clear completes
- vram_en, vram_we  out  1 each  VRAM port enable and write enable
- vram_addr  out  ADDR_W  VRAM address
- vram_wdata  out  DATA_W  VRAM write data
- vram_rdata  in  DATA_W  VRAM read data, one-cycle synchronous latency

## Operation
- Fixed priority: display > host > clear. At most one VRAM access per cycle.
- VRAM port outputs are a combinational mux of the granted requester. When nothing is granted, vram_en=0, vram_we=0, addr=0, wdata=0.
- Display:
  - disp_req is always granted.
  - vram_en=1, we=0, addr=disp_addr.
- Host:
  - host_ready = !disp_req && !clr_busy.
  - An accepted write drives en=1, we=1 with host_addr and host_wdata.
  - If host_addr >= H_ACTIVE*V_ACTIVE (307200), the write is accepted (handshake completes) but dropped, with vram_en=0.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: on clr_start, latch clr_color, set count=0, go to CLEAR.
  - CLEAR:
    - clr_busy=1.
    - In each cycle where disp_req=0: write count with the latched colour, then count++.
    - When the write at count=307199 occurs, go to DONE.
    - Cycles with disp_req=1 stall the engine; count holds.
  - DONE: clr_done=1 for one cycle, clr_busy=0, then return to IDLE.
- clr_start in CLEAR or DONE is ignored.
- clr_start and host_valid arriving in the same IDLE cycle: the host write is accepted that cycle (ready is still 1, since busy is not yet set). The clear begins the next cycle.
- Count is ADDR_W bits. It never exceeds 307199 and does not wrap.

## Timing
- Reset values:
  - disp_rvalid=0, clr_busy=0, clr_done=0, state=IDLE, count=0, latched colour=0.
  - host_ready=1 (combinational, when disp_req=0).
  - vram_* all 0 when no request is present.
- Display latency: disp_req at cycle n gives disp_rvalid=1 and valid disp_rdata at cycle n+1. Back-to-back requests give one pixel per cycle.
- Host write: commits in the accept cycle and is visible to a read issued the following cycle.
- Clear duration: 307200 + (number of disp_req cycles during CLEAR) cycles from entering CLEAR to the last write. clr_done asserts the cycle after the last write.
- clr_busy rises the cycle after the accepted clr_start and falls in the DONE cycle.
- Reset mid-clear:
  - The FSM returns to IDLE and clr_busy falls asynchronously.
  - No clr_done pulse is produced.
  - Partially cleared pixels keep their values.

## Test plan
- Reset: hold rstn=0 → disp_rvalid=0, clr_busy=0, clr_done=0, vram_en=0. Then release with no requests → outputs unchanged.
- Display read: preload addr 1234 = 8'hE3, pulse disp_req with disp_addr=1234 at cycle n → vram_en=1 and we=0 at cycle n; disp_rvalid=1 and disp_rdata=8'hE3 at cycle n+1.
- Host conflict: host_valid=1 (addr 100, data 8'h1C) while disp_req=1 for 3 cycles → host_ready=0 for those 3 cycles; the write is accepted in the 4th cycle and a read of addr 100 returns 8'h1C. A write to addr 307200 is accepted, but vram_en=0.
- Full clear, idle display: clr_start with clr_color=8'hFF → clr_done exactly 307201 cycles after clr_start; every VRAM location reads 8'hFF. clr_start re-issued mid-clear has no effect.
- Clear with display traffic: disp_req asserted on alternate cycles throughout → last clear write after 614399 CLEAR cycles; no display read is delayed (disp_rvalid follows each disp_req by 1 cycle); host_ready=0 throughout CLEAR.
- Reset mid-clear: assert rstn=0 at count 1000 → clr_busy=0 immediately and no clr_done pulse. Addresses 0..999 hold the clear colour; address 1000 and above are unchanged.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter for the RGB332 frame buffer: display reads > host writes > clear engine.
// Display reads are never stalled; the clear engine only uses cycles the display leaves idle.
module vram_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              vram_en,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata
);
    localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

    clr_state_t        state;
    logic [ADDR_W-1:0] count;
    logic [DATA_W-1:0] color;
    logic              host_in_range;

    assign host_ready    = !disp_req && !clr_busy;
    assign host_in_range = host_addr < FRAME_END;
    assign disp_rdata    = vram_rdata;

    // Out-of-range host writes still complete the handshake but never reach the VRAM.
    always_comb begin
        vram_en    = 1'b0;
        vram_we    = 1'b0;
        vram_addr  = '0;
        vram_wdata = '0;
        if (disp_req) begin
            vram_en   = 1'b1;
            vram_addr = disp_addr;
        end else if (host_valid && host_ready) begin
            if (host_in_range) begin
                vram_en    = 1'b1;
                vram_we    = 1'b1;
                vram_addr  = host_addr;
                vram_wdata = host_wdata;
            end
        end else if (state == CLEAR) begin
            vram_en    = 1'b1;
            vram_we    = 1'b1;
            vram_addr  = count;
            vram_wdata = color;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            disp_rvalid <= 1'b0;
        end else begin
            disp_rvalid <= disp_req;
        end
    end

    // Clear engine: stalls whenever the display owns the port, so count only advances on writes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            count    <= '0;
            color    <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_start) begin
                        color    <= clr_color;
                        count    <= '0;
                        clr_busy <= 1'b1;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (!disp_req) begin
                        if (count == LAST_ADDR) begin
                            clr_busy <= 1'b0;
                            clr_done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    clr_done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
